ula_sequencer: RTL and testbench



---
 rtl/ula_sequencer_pkg.sv | 46 ++++
 rtl/ula_sequencer_if.sv | 29 ++
 rtl/rca_sixteen_bits.sv | 24 ++
 rtl/ula_sequencer.sv | 133 +++++++++++++
 tb/tb_ula_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_sequencer_pkg
// Description : Shared types, constants and bit-level helpers for ula_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package ula_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MUL_ITER = 3'd2,
        ST_MUL_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int          MUL_ITERS   = 8;
    localparam logic [2:0]  C_LAST_ITER = 3'(MUL_ITERS - 1);

    // Magnitude without an adder: two's-complement negate keeps bits up to and
    // including the lowest set bit and inverts everything above it.
    function automatic logic [7:0] mag8(input logic [7:0] x);
        logic seen;
        mag8 = x;
        seen = 1'b0;
        if (x[7]) begin
            for (int i = 0; i < 8; i++) begin
                if (seen) mag8[i] = ~x[i];
                if (x[i]) seen = 1'b1;
            end
        end
    endfunction

    function automatic logic [2:0] inc3(input logic [2:0] x);
        return {x[2] ^ (x[1] & x[0]), x[1] ^ x[0], ~x[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ula_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ula_sequencer_if
// Description : Request/result handshake bundle for ula_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface ula_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        sign_flag;
    logic        zero_flag;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, sign_flag, zero_flag
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, sign_flag, zero_flag
    );
endinterface
`default_nettype wire

// File: rtl/rca_sixteen_bits.sv
`default_nettype none
// ============================================================================
// Module      : rca_sixteen_bits
// Description : 16-bit ripple-carry adder built from full-adder cells.
// Revision    : 1.0  initial release
// ============================================================================
module rca_sixteen_bits (
    input  wire logic [15:0] i_a,
    input  wire logic [15:0] i_b,
    input  wire logic        i_cin,
    output logic      [15:0] o_sum
);
    logic [15:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
        if (i < 15) begin : g_carry
            assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end
endmodule
`default_nettype wire

// File: rtl/ula_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ula_sequencer
// Description : Sequenced ADD/SUB/NOP/signed-MUL unit sharing one 16-bit adder.
// Revision    : 1.0  initial release
// ============================================================================
module ula_sequencer
    import ula_sequencer_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    ula_sequencer_if.slave  bus
);
    state_e      r_state, w_next;
    op_e         r_op;
    logic [7:0]  r_a, r_b, r_mplier;
    logic [15:0] r_mcand, r_acc, r_result;
    logic [2:0]  r_cnt;
    logic        r_neg, r_sign, r_zero;
    logic [15:0] w_add_a, w_add_b, w_sum;
    logic        w_cin, w_accept;

    assign bus.in_ready  = (r_state == ST_IDLE) && !reset;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.sign_flag = r_sign;
    assign bus.zero_flag = r_zero;
    assign w_accept      = bus.in_valid && bus.in_ready;

    rca_sixteen_bits u_adder (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_cin (w_cin),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_next = (op_e'(bus.op) == OP_MUL) ? ST_MUL_ITER : ST_EXEC;
            ST_EXEC:     w_next = ST_DONE;
            ST_MUL_ITER: if (r_cnt == C_LAST_ITER) w_next = ST_MUL_FIX;
            ST_MUL_FIX:  w_next = ST_DONE;
            ST_DONE:     if (bus.out_ready) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Shared adder operand selection; NOP leaves all operands zero.
    always_comb begin
        w_add_a = 16'h0000;
        w_add_b = 16'h0000;
        w_cin   = 1'b0;
        case (r_state)
            ST_EXEC: begin
                case (r_op)
                    OP_ADD: begin
                        w_add_a = {{8{r_a[7]}}, r_a};
                        w_add_b = {{8{r_b[7]}}, r_b};
                    end
                    OP_SUB: begin
                        w_add_a = {{8{r_a[7]}}, r_a};
                        w_add_b = ~{{8{r_b[7]}}, r_b};
                        w_cin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MUL_ITER: begin
                w_add_a = r_acc;
                w_add_b = r_mplier[0] ? r_mcand : 16'h0000;
            end
            ST_MUL_FIX: begin
                if (r_neg && (r_acc != 16'h0000)) begin
                    w_add_a = ~r_acc;
                    w_cin   = 1'b1;
                end else begin
                    w_add_a = r_acc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_ADD;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_mplier <= 8'h00;
            r_mcand  <= 16'h0000;
            r_acc    <= 16'h0000;
            r_cnt    <= 3'd0;
            r_neg    <= 1'b0;
            r_result <= 16'h0000;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= op_e'(bus.op);
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_acc    <= 16'h0000;
                        r_mcand  <= {8'h00, mag8(bus.a)};
                        r_mplier <= mag8(bus.b);
                        r_neg    <= bus.a[7] ^ bus.b[7];
                        r_cnt    <= 3'd0;
                    end
                end
                ST_MUL_ITER: begin
                    r_acc    <= w_sum;
                    r_mcand  <= {r_mcand[14:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[7:1]};
                    r_cnt    <= inc3(r_cnt);
                end
                ST_EXEC, ST_MUL_FIX: begin
                    r_result <= w_sum;
                    r_sign   <= w_sum[15];
                    r_zero   <= (w_sum == 16'h0000);
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ula_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_sequencer
// Description : Scoreboard-based self-checking bench for ula_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ula_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [15:0] exp_q[$];

    ula_sequencer_if bus();

    ula_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        case (op)
            2'b00:   return sa + sb;
            2'b01:   return sa - sb;
            2'b10:   return sa * sb;
            default: return 16'h0000;
        endcase
    endfunction

    // Waits for in_ready, presents one request for exactly the accepting edge,
    // then scrambles the inputs so late changes would corrupt a non-capturing DUT.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 2'($urandom);
        bus.a  = 8'($urandom);
        bus.b  = 8'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready, bus.result, bus.sign_flag, bus.zero_flag} !== 20'h0) begin
            bad++;
            $display("FAIL reset_active got ov=%b ir=%b res=%h s=%b z=%b want all 0",
                     bus.out_valid, bus.in_ready, bus.result, bus.sign_flag, bus.zero_flag);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.sign_flag, bus.zero_flag} !== {1'b1, 19'h0}) begin
            bad++;
            $display("FAIL reset_release got ir=%b ov=%b res=%h s=%b z=%b want ir=1 rest 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.sign_flag, bus.zero_flag);
        end
    endtask

    task automatic run_table(input string name, input int want_lat, input logic [1:0] ops[6],
                             input logic [7:0] as[6], input logic [7:0] bs[6]);
        int lat;
        logic [15:0] e;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_out(lat);
            e = exp_q.pop_front();
            total++;
            if (lat !== want_lat) begin
                bad++;
                $display("FAIL %s[%0d] latency got=%0d want=%0d", name, i, lat, want_lat);
            end
            total++;
            if ({bus.result, bus.sign_flag, bus.zero_flag} !== {e, e[15], e == 16'h0000}) begin
                bad++;
                $display("FAIL %s[%0d] result got=%h s=%b z=%b want=%h s=%b z=%b", name, i,
                         bus.result, bus.sign_flag, bus.zero_flag, e, e[15], e == 16'h0000);
            end
            release_out();
        end
    endtask

    task automatic test_add_sub();
        logic [1:0] ops[6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01};
        logic [7:0] as[6]  = '{8'h7F, 8'h00, 8'h05, 8'h80, 8'h03, 8'h80};
        logic [7:0] bs[6]  = '{8'h01, 8'h80, 8'h05, 8'h80, 8'h09, 8'h7F};
        run_table("add_sub", 2, ops, as, bs);
    endtask

    task automatic test_mul();
        logic [1:0] ops[6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [7:0] as[6]  = '{8'h80, 8'hFD, 8'h80, 8'h00, 8'h7F, 8'hFF};
        logic [7:0] bs[6]  = '{8'h80, 8'h07, 8'h7F, 8'h05, 8'h7F, 8'hFF};
        run_table("mul", 10, ops, as, bs);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] e;
        issue(2'b00, 8'h10, 8'h20);
        wait_out(lat);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op = 2'b00;
            bus.a  = 8'h01;
            bus.b  = 8'h01;
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.in_ready, bus.result, bus.sign_flag, bus.zero_flag} !==
                {1'b1, 1'b0, e, e[15], e == 16'h0000}) begin
                bad++;
                $display("FAIL hold[%0d] got ov=%b ir=%b res=%h s=%b z=%b want ov=1 ir=0 res=%h",
                         i, bus.out_valid, bus.in_ready, bus.result, bus.sign_flag, bus.zero_flag, e);
            end
        end
        bus.in_valid = 1'b0;
        release_out();
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b0, 1'b1, e}) begin
            bad++;
            $display("FAIL hold_release got ov=%b ir=%b res=%h want ov=0 ir=1 res=%h",
                     bus.out_valid, bus.in_ready, bus.result, e);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        int stale;
        logic [15:0] e;
        issue(2'b00, 8'h03, 8'h04);
        wait_out(lat);
        e = exp_q.pop_front();
        total++;
        if (bus.result !== e) begin
            bad++;
            $display("FAIL pre_reset_add got=%h want=%h", bus.result, e);
        end
        release_out();
        issue(2'b10, 8'h80, 8'h7F);
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.out_valid, bus.in_ready, bus.result, bus.sign_flag, bus.zero_flag} !== 20'h0) begin
            bad++;
            $display("FAIL mid_mul_reset got ov=%b ir=%b res=%h s=%b z=%b want all 0",
                     bus.out_valid, bus.in_ready, bus.result, bus.sign_flag, bus.zero_flag);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_mul_ready got=%b want=1", bus.in_ready);
        end
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
        end
        total++;
        if (stale !== 0) begin
            bad++;
            $display("FAIL mid_mul_stale got=%0d out_valid cycles want=0", stale);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops[6] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        logic [7:0] as[6]  = '{8'h00, 8'h12, 8'hF0, 8'h44, 8'h0C, 8'h81};
        logic [7:0] bs[6]  = '{8'h55, 8'h34, 8'h10, 8'h55, 8'hF6, 8'hFF};
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) issue(ops[i], as[i], bs[i]);
            end
            begin
                int got;
                int cyc;
                logic [15:0] e;
                got = 0;
                cyc = 0;
                while (got < 6 && cyc < 400) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.out_valid) begin
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                        total++;
                        if ({bus.result, bus.sign_flag, bus.zero_flag, bus.in_ready} !==
                            {e, e[15], e == 16'h0000, 1'b0}) begin
                            bad++;
                            $display("FAIL b2b[%0d] got res=%h s=%b z=%b ir=%b want res=%h s=%b z=%b ir=0",
                                     got, bus.result, bus.sign_flag, bus.zero_flag, bus.in_ready,
                                     e, e[15], e == 16'h0000);
                        end
                        got++;
                    end
                end
                total++;
                if (got !== 6) begin
                    bad++;
                    $display("FAIL b2b_count got=%0d want=6", got);
                end
            end
        join
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_add_sub();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
